alu_rr_iterative: RTL and testbench

ALU_RR_ITERATIVE -- requirements
Module: alu_rr_iterative

---
 rtl/alu_rr_iterative.sv | 140 ++++++++++++++
 tb/tb_alu_rr_iterative.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_iterative.sv
// RV32/64 integer ALU with an iterative shift-add multiplier and a valid/ready
// handshake on both sides. Base ops answer in one cycle, multiplies in XLEN+1.
module alu_rr_iterative #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] operand_0,
  input  logic [XLEN-1:0] operand_1,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] destination,
  output logic            illegal
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

  state_t            state;
  logic [SHW-1:0]    step;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   mcand;
  logic              negate;
  logic              want_hi;

  logic              transfer;
  logic              is_base, is_alt, is_mul, legal;
  logic [SHW-1:0]    shamt;
  logic [XLEN-1:0]   base_result;
  logic              sign_0, sign_1;
  logic [XLEN-1:0]   mag_0, mag_1;
  logic [XLEN:0]     partial;
  logic [2*XLEN-1:0] acc_next;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   mul_result;

  assign in_ready = reset_n & ((state == IDLE) | ((state == HOLD) & out_ready));
  assign transfer = in_valid & in_ready;

  // Request decode and the single-cycle datapath.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    base_result = '0;
    is_base     = (funct7 == 7'h00);
    is_alt      = (funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5));
    is_mul      = (funct7 == 7'h01) && !funct3[2];
    legal       = is_base | is_alt | is_mul;
    shamt       = operand_1[SHW-1:0];
    if (is_base) begin
      case (funct3)
        3'd0:    base_result = operand_0 + operand_1;
        3'd1:    base_result = operand_0 << shamt;
        3'd2:    base_result = {{(XLEN-1){1'b0}}, $signed(operand_0) < $signed(operand_1)};
        3'd3:    base_result = {{(XLEN-1){1'b0}}, operand_0 < operand_1};
        3'd4:    base_result = operand_0 ^ operand_1;
        3'd5:    base_result = operand_0 >> shamt;
        3'd6:    base_result = operand_0 | operand_1;
        default: base_result = operand_0 & operand_1;
      endcase
    end else if (is_alt) begin
      base_result = funct3[2] ? $unsigned($signed(operand_0) >>> shamt)
                              : operand_0 - operand_1;
    end
  end

  // Multiplies run on magnitudes; MULH treats both sides as signed, MULHSU only rs1.
  always_comb begin
    sign_0 = operand_0[XLEN-1] & ((funct3 == 3'd1) || (funct3 == 3'd2));
    sign_1 = operand_1[XLEN-1] & (funct3 == 3'd1);
    mag_0  = sign_0 ? -operand_0 : operand_0;
    mag_1  = sign_1 ? -operand_1 : operand_1;
  end

  // One shift-add step: the multiplier sits in acc's low half and drains out LSB-first.
  always_comb begin
    partial    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : {(XLEN+1){1'b0}});
    acc_next   = {partial, acc[XLEN-1:1]};
    prod       = negate ? -acc_next : acc_next;
    mul_result = want_hi ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    if (!reset_n) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      destination <= '0;
      illegal     <= 1'b0;
      step        <= '0;
      acc         <= '0;
      mcand       <= '0;
      negate      <= 1'b0;
      want_hi     <= 1'b0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (transfer) begin
            if (is_mul) begin
              state     <= MUL;
              out_valid <= 1'b0;
              step      <= '0;
              acc       <= {{XLEN{1'b0}}, mag_1};
              mcand     <= mag_0;
              negate    <= sign_0 ^ sign_1;
              want_hi   <= (funct3 != 3'd0);
            end else begin
              state       <= HOLD;
              out_valid   <= 1'b1;
              destination <= base_result;
              illegal     <= !legal;
            end
          end else if ((state == HOLD) && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        MUL: begin
          acc  <= acc_next;
          step <= step + SHW'(1);
          if (step == SHW'(XLEN - 1)) begin
            state       <= HOLD;
            out_valid   <= 1'b1;
            destination <= mul_result;
            illegal     <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_iterative.sv
// Self-checking bench for alu_rr_iterative: a transaction-level model checks the
// 32-bit instance every cycle; directed cases pin literals on 32- and 16-bit instances.
module tb_alu_rr_iterative;

  logic        clock = 1'b0;
  logic        reset_n;

  logic        in_valid, in_ready, out_valid, out_ready, illegal;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] operand_0, operand_1, destination;

  logic        in_valid_16, in_ready_16, out_valid_16, out_ready_16, illegal_16;
  logic [2:0]  funct3_16;
  logic [6:0]  funct7_16;
  logic [15:0] operand_0_16, operand_1_16, destination_16;

  int n_total = 0;
  int n_pass  = 0;
  bit cmp_en  = 1'b0;

  // Transaction model state for the 32-bit instance.
  int          busy    = 0;
  bit          m_valid = 1'b0;
  logic [63:0] m_dest  = '0;
  logic        m_ill   = 1'b0;
  logic [63:0] p_dest  = '0;
  logic [63:0] r_dest;
  logic        r_ill;
  bit          rdy_pre;

  always #5 clock = ~clock;

  alu_rr_iterative #(.XLEN(32)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .funct7(funct7), .operand_0(operand_0), .operand_1(operand_1),
    .out_valid(out_valid), .out_ready(out_ready), .destination(destination), .illegal(illegal)
  );

  alu_rr_iterative #(.XLEN(16)) dut16 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid_16), .in_ready(in_ready_16),
    .funct3(funct3_16), .funct7(funct7_16), .operand_0(operand_0_16), .operand_1(operand_1_16),
    .out_valid(out_valid_16), .out_ready(out_ready_16), .destination(destination_16),
    .illegal(illegal_16)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // Reference ALU computed with wide plain arithmetic on sign-extended values.
  function automatic void model(input int xlen, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [63:0] a_in, input logic [63:0] b_in,
                                output logic [63:0] dest, output logic ill);
    logic [127:0] mask, ua, ub, sa, sb, full;
    int sh;
    mask = (128'd1 << xlen) - 128'd1;
    ua   = {64'd0, a_in} & mask;
    ub   = {64'd0, b_in} & mask;
    sa   = ua[xlen-1] ? ua - (128'd1 << xlen) : ua;
    sb   = ub[xlen-1] ? ub - (128'd1 << xlen) : ub;
    sh   = int'(ub[5:0]) % xlen;
    ill  = 1'b0;
    full = '0;
    case (f7)
      7'h00: case (f3)
        3'd0: full = ua + ub;
        3'd1: full = ua << sh;
        3'd2: full = {127'd0, $signed(sa) < $signed(sb)};
        3'd3: full = {127'd0, ua < ub};
        3'd4: full = ua ^ ub;
        3'd5: full = ua >> sh;
        3'd6: full = ua | ub;
        default: full = ua & ub;
      endcase
      7'h20: begin
        if (f3 == 3'd0)      full = ua - ub;
        else if (f3 == 3'd5) full = $signed(sa) >>> sh;
        else                 ill = 1'b1;
      end
      7'h01: case (f3)
        3'd0: full = ua * ub;
        3'd1: full = (sa * sb) >> xlen;
        3'd2: full = (sa * ub) >> xlen;
        3'd3: full = (ua * ub) >> xlen;
        default: ill = 1'b1;
      endcase
      default: ill = 1'b1;
    endcase
    full = ill ? 128'd0 : (full & mask);
    dest = full[63:0];
  endfunction

  always @(posedge clock) begin
    if (!reset_n) begin
      busy = 0; m_valid = 1'b0; m_dest = '0; m_ill = 1'b0;
    end else begin
      rdy_pre = (busy == 0 && !m_valid) || (m_valid && out_ready);
      if (busy > 0) begin
        busy--;
        if (busy == 0) begin m_valid = 1'b1; m_dest = p_dest; m_ill = 1'b0; end
      end else if (in_valid && rdy_pre) begin
        model(32, funct3, funct7, {32'd0, operand_0}, {32'd0, operand_1}, r_dest, r_ill);
        if (funct7 == 7'h01 && !r_ill) begin busy = 32; m_valid = 1'b0; p_dest = r_dest; end
        else begin m_valid = 1'b1; m_dest = r_dest; m_ill = r_ill; end
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      check("in_ready", {63'd0, in_ready},
            {63'd0, reset_n && ((busy == 0 && !m_valid) || (m_valid && out_ready))});
      check("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
      if (m_valid) begin
        check("destination", {32'd0, destination}, m_dest);
        check("illegal", {63'd0, illegal}, {63'd0, m_ill});
      end
    end
  end

  task automatic run_op(input bit w16, input string name, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_dest, input logic exp_ill, input int exp_lat);
    int lat;
    bit seen;
    bit quiet;
    @(posedge clock); #1;
    if (w16) begin
      in_valid_16 = 1'b1; funct3_16 = f3; funct7_16 = f7;
      operand_0_16 = a[15:0]; operand_1_16 = b[15:0];
    end else begin
      in_valid = 1'b1; funct3 = f3; funct7 = f7;
      operand_0 = a[31:0]; operand_1 = b[31:0]; out_ready = 1'b1;
    end
    #1 check({name, "_accept"}, {63'd0, w16 ? in_ready_16 : in_ready}, 64'd1);
    @(posedge clock); #1;
    in_valid = 1'b0; in_valid_16 = 1'b0;
    operand_0 = $urandom; operand_1 = $urandom; funct3 = 3'($urandom);
    operand_0_16 = 16'($urandom); operand_1_16 = 16'($urandom); funct3_16 = 3'($urandom);
    lat = 0; seen = 1'b0; quiet = 1'b1;
    for (int i = 1; i <= 200 && !seen; i++) begin
      @(negedge clock);
      if (w16 ? out_valid_16 : out_valid) begin seen = 1'b1; lat = i; end
      else if (w16 ? in_ready_16 : in_ready) quiet = 1'b0;
    end
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    check({name, "_dest"}, w16 ? {48'd0, destination_16} : {32'd0, destination}, exp_dest);
    check({name, "_illegal"}, {63'd0, w16 ? illegal_16 : illegal}, {63'd0, exp_ill});
    if (exp_lat > 1) check({name, "_busy_not_ready"}, {63'd0, quiet}, 64'd1);
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  logic [63:0] md;
  logic        mi;
  logic [2:0]  rf3;
  logic [6:0]  rf7;
  logic [63:0] ra, rb;
  logic [31:0] sum_exp [4];
  bit          leaked;

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; funct3 = '0; funct7 = '0;
    operand_0 = '0; operand_1 = '0;
    in_valid_16 = 1'b0; out_ready_16 = 1'b1; funct3_16 = '0; funct7_16 = '0;
    operand_0_16 = '0; operand_1_16 = '0;

    // Pin the reference model to hand-computed results.
    model(32, 3'd0, 7'h00, 64'd7, 64'hFFFF_FFFD, md, mi); check("model_add", md, 64'd4);
    model(32, 3'd5, 7'h20, 64'h8000_0000, 64'h24, md, mi); check("model_sra", md, 64'hF800_0000);
    model(32, 3'd1, 7'h01, 64'h8000_0000, 64'h8000_0000, md, mi); check("model_mulh", md, 64'h4000_0000);
    model(16, 3'd1, 7'h01, 64'h8000, 64'h2, md, mi); check("model_mulh16", md, 64'hFFFF);
    model(32, 3'd1, 7'h20, 64'd5, 64'd6, md, mi); check("model_illegal", {63'd0, mi}, 64'd1);

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_in_ready", {63'd0, in_ready}, 64'd0);
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_destination", {32'd0, destination}, 64'd0);
    check("reset_illegal", {63'd0, illegal}, 64'd0);
    check("reset_out_valid_16", {63'd0, out_valid_16}, 64'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    cmp_en  = 1'b1;

    run_op(0, "add",    3'd0, 7'h00, 64'd7, 64'hFFFF_FFFD, 64'd4, 1'b0, 1);
    run_op(0, "sra",    3'd5, 7'h20, 64'h8000_0000, 64'h24, 64'hF800_0000, 1'b0, 1);
    run_op(0, "srl",    3'd5, 7'h00, 64'h8000_0000, 64'h24, 64'h0800_0000, 1'b0, 1);
    run_op(0, "slt",    3'd2, 7'h00, 64'hFFFF_FFFF, 64'd1, 64'd1, 1'b0, 1);
    run_op(0, "sltu",   3'd3, 7'h00, 64'hFFFF_FFFF, 64'd1, 64'd0, 1'b0, 1);
    run_op(0, "mulh",   3'd1, 7'h01, 64'h8000_0000, 64'h8000_0000, 64'h4000_0000, 1'b0, 33);
    run_op(0, "mulhu",  3'd3, 7'h01, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE, 1'b0, 33);
    run_op(0, "mul",    3'd0, 7'h01, 64'hFFFF_FFFF, 64'd3, 64'hFFFF_FFFD, 1'b0, 33);
    run_op(0, "mulhsu", 3'd2, 7'h01, 64'hFFFF_FFFF, 64'd2, 64'hFFFF_FFFF, 1'b0, 33);
    run_op(0, "ill_f7", 3'd0, 7'h02, 64'd9, 64'd4, 64'd0, 1'b1, 1);
    run_op(0, "ill_alt", 3'd1, 7'h20, 64'd9, 64'd4, 64'd0, 1'b1, 1);
    run_op(0, "ill_mul", 3'd4, 7'h01, 64'd9, 64'd4, 64'd0, 1'b1, 1);

    // Backpressure: result must sit still while out_ready is low.
    @(posedge clock); #1;
    out_ready = 1'b0; in_valid = 1'b1; funct3 = 3'd0; funct7 = 7'h00;
    operand_0 = 32'd100; operand_1 = 32'd23;
    @(posedge clock); #1;
    in_valid = 1'b0; operand_0 = $urandom;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("hold_valid", {63'd0, out_valid}, 64'd1);
      check("hold_dest", {32'd0, destination}, 64'd123);
      check("hold_not_ready", {63'd0, in_ready}, 64'd0);
    end
    // Streaming: four ADDs back to back, one result per cycle.
    @(posedge clock); #1;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) sum_exp[k] = 32'(1000 * (k + 1) + k);
    operand_0 = 32'd1000; operand_1 = 32'd0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clock); #1;
      if (k < 3) begin operand_0 = 32'(1000 * (k + 2)); operand_1 = 32'(k + 1); end
      else in_valid = 1'b0;
      @(negedge clock);
      check("stream_valid", {63'd0, out_valid}, 64'd1);
      check("stream_dest", {32'd0, destination}, {32'd0, sum_exp[k]});
    end

    // Reset in the middle of a multiply discards it.
    @(posedge clock); #1;
    in_valid = 1'b1; funct3 = 3'd1; funct7 = 7'h01; operand_0 = 32'h1234_5678; operand_1 = 32'd3;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clock);
    #1 reset_n = 1'b0;
    @(negedge clock);
    check("abort_in_ready", {63'd0, in_ready}, 64'd0);
    check("abort_out_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    check("abort_idle_ready", {63'd0, in_ready}, 64'd1);
    leaked = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (out_valid) leaked = 1'b1;
    end
    check("abort_no_result", {63'd0, leaked}, 64'd0);

    // Randomized traffic with random backpressure and occasional resets.
    for (int c = 0; c < 2500; c++) begin
      @(posedge clock); #1;
      reset_n   = ($urandom_range(0, 299) != 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      funct3    = 3'($urandom);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: funct7 = 7'h00;
        5:             begin funct7 = 7'h20; if ($urandom_range(0, 3) != 0) funct3 = {funct3[0], 2'b01} & 3'b101; end
        6, 7, 8:       funct7 = 7'h01;
        default:       funct7 = 7'($urandom);
      endcase
      operand_0 = rand_word();
      operand_1 = rand_word();
    end
    @(posedge clock); #1;
    reset_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (40) @(posedge clock);

    run_op(1, "mulh16", 3'd1, 7'h01, 64'h8000, 64'h0002, 64'hFFFF, 1'b0, 17);
    run_op(1, "sll16",  3'd1, 7'h00, 64'h0001, 64'h0013, 64'h0008, 1'b0, 1);
    for (int j = 0; j < 24; j++) begin
      rf3 = 3'($urandom);
      case ($urandom_range(0, 3))
        0:       rf7 = 7'h00;
        1:       rf7 = 7'h20;
        2:       rf7 = 7'h01;
        default: rf7 = 7'($urandom);
      endcase
      ra = {48'd0, 16'(rand_word())};
      rb = {48'd0, 16'(rand_word())};
      model(16, rf3, rf7, ra, rb, md, mi);
      run_op(1, "rand16", rf3, rf7, ra, rb, md, mi, (rf7 == 7'h01 && !rf3[2]) ? 17 : 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
